// File: rtl/register_file_8x16.sv
// Eight-entry register file: one write port, two combinational read ports,
// optional same-cycle write forwarding, optional hard-wired zero register and a write counter.
module register_file_8x16 #(
  parameter int WIDTH   = 16,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WE,
  input  logic [2:0]       WA,
  input  logic [WIDTH-1:0] WD,
  input  logic [2:0]       RA,
  input  logic [2:0]       RB,
  output logic [WIDTH-1:0] QA,
  output logic [WIDTH-1:0] QB,
  output logic [7:0]       WCNT
);

  localparam int NUM_REGS  = 8;
  localparam int NUM_PORTS = 2;

  logic [WIDTH-1:0] regs_reg [NUM_REGS];
  logic [7:0]       wcnt_reg;
  logic [7:0]       wcnt_next;
  logic             commit;

  // A write to R0 is not a committed write when R0 is hard-wired to zero.
  assign commit    = WE && !((ZERO_R0 != 0) && (WA == 3'd0));
  assign wcnt_next = wcnt_reg + 8'd1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_reg[gi] <= '0;
        end else if (commit && (WA == 3'(gi))) begin
          regs_reg[gi] <= WD;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_reg <= 8'd0;
    end else if (commit) begin
      wcnt_reg <= wcnt_next;
    end
  end

  logic [2:0]       raddr [NUM_PORTS];
  logic [WIDTH-1:0] rdata [NUM_PORTS];

  assign raddr[0] = RA;
  assign raddr[1] = RB;

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rport
      // Forwarding keys off the commit qualifier so a discarded R0 write is never forwarded.
      always_comb begin
        rdata[gi] = regs_reg[raddr[gi]];
        if ((BYPASS != 0) && commit && (WA == raddr[gi])) begin
          rdata[gi] = WD;
        end
        if ((ZERO_R0 != 0) && (raddr[gi] == 3'd0)) begin
          rdata[gi] = '0;
        end
      end
    end
  endgenerate

  assign QA   = rdata[0];
  assign QB   = rdata[1];
  assign WCNT = wcnt_reg;

endmodule

// File: tb/tb_register_file_8x16.sv
// Scoreboard bench: one default instance (forwarding, zero R0) and one with
// forwarding and zero-R0 disabled, driven from shared inputs and checked against a reference model.
module tb_register_file_8x16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        WE  = 1'b0;
  logic [2:0]  WA  = 3'd0;
  logic [15:0] WD  = 16'd0;
  logic [2:0]  RA  = 3'd0;
  logic [2:0]  RB  = 3'd0;
  logic [15:0] QA, QB, QA_nb, QB_nb;
  logic [7:0]  WCNT, WCNT_nb;

  always #5 clk = ~clk;

  register_file_8x16 #(.WIDTH(16), .BYPASS(1), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst), .WE(WE), .WA(WA), .WD(WD), .RA(RA), .RB(RB),
    .QA(QA), .QB(QB), .WCNT(WCNT)
  );

  register_file_8x16 #(.WIDTH(16), .BYPASS(0), .ZERO_R0(0)) dut_nb (
    .clk(clk), .rst(rst), .WE(WE), .WA(WA), .WD(WD), .RA(RA), .RB(RB),
    .QA(QA_nb), .QB(QB_nb), .WCNT(WCNT_nb)
  );

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  logic [15:0] exp_q [$];

  // Reference state: m* for the default instance, n* for the no-bypass/no-zero instance.
  logic [15:0] mreg [8];
  logic [15:0] nreg [8];
  logic [7:0]  mcnt, ncnt;
  bit          mvalid = 1'b0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d got=%h exp=%h", tag, txn, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_main(input logic [2:0] a, input logic we,
                                           input logic [2:0] wa, input logic [15:0] wd);
    if (a == 3'd0) return 16'h0000;
    if (we && (wa == a)) return wd;
    return mreg[a];
  endfunction

  task automatic do_cycle(input logic r, input logic we, input logic [2:0] wa,
                          input logic [15:0] wd, input logic [2:0] ra, input logic [2:0] rb);
    logic [15:0] e;
    @(negedge clk);
    rst = r; WE = we; WA = wa; WD = wd; RA = ra; RB = rb;
    if (mvalid) begin
      exp_q.push_back(exp_main(ra, we, wa, wd));
      exp_q.push_back(exp_main(rb, we, wa, wd));
      exp_q.push_back({8'd0, mcnt});
      exp_q.push_back(nreg[ra]);
      exp_q.push_back(nreg[rb]);
      exp_q.push_back({8'd0, ncnt});
    end
    #1;
    if (mvalid) begin
      e = exp_q.pop_front(); chk("qa",      QA,              e);
      e = exp_q.pop_front(); chk("qb",      QB,              e);
      e = exp_q.pop_front(); chk("wcnt",    {8'd0, WCNT},    e);
      e = exp_q.pop_front(); chk("qa_nb",   QA_nb,           e);
      e = exp_q.pop_front(); chk("qb_nb",   QB_nb,           e);
      e = exp_q.pop_front(); chk("wcnt_nb", {8'd0, WCNT_nb}, e);
    end
    $display("txn %0d rst=%b we=%b wa=%0d wd=%h ra=%0d rb=%0d | qa=%h qb=%h wcnt=%0d | qa_nb=%h qb_nb=%h wcnt_nb=%0d",
             txn, r, we, wa, wd, ra, rb, QA, QB, WCNT, QA_nb, QB_nb, WCNT_nb);
    txn++;
    if (r) begin
      for (int i = 0; i < 8; i++) begin
        mreg[i] = 16'h0000;
        nreg[i] = 16'h0000;
      end
      mcnt   = 8'd0;
      ncnt   = 8'd0;
      mvalid = 1'b1;
    end else if (we) begin
      if (wa != 3'd0) begin
        mreg[wa] = wd;
        mcnt     = mcnt + 8'd1;
      end
      nreg[wa] = wd;
      ncnt     = ncnt + 8'd1;
    end
  endtask

  initial begin
    logic [15:0] last_wd;

    // Reset for two cycles, then idle reads of R3/R7.
    do_cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd7);
    do_cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd7);
    do_cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd7);

    // Write R5, then read it back next cycle alongside an unwritten register.
    do_cycle(1'b0, 1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd4);
    do_cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd4);

    // Write to R0: discarded on the zero-R0 instance, stored on the other.
    do_cycle(1'b0, 1'b1, 3'd0, 16'h1234, 3'd0, 3'd5);
    do_cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);

    // Same-cycle forwarding versus pre-write value.
    do_cycle(1'b0, 1'b1, 3'd2, 16'hA5A5, 3'd2, 3'd2);
    do_cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd2);

    // Rewriting the held value still counts.
    do_cycle(1'b0, 1'b1, 3'd2, 16'hA5A5, 3'd2, 3'd5);
    do_cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd5);

    // Reset wins over a simultaneous write; all prior contents discarded.
    do_cycle(1'b1, 1'b1, 3'd6, 16'hFFFF, 3'd5, 3'd5);
    do_cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd5);
    do_cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd0);

    // Write in the first post-reset cycle is forwarded.
    do_cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
    do_cycle(1'b0, 1'b1, 3'd3, 16'h5A5A, 3'd3, 3'd1);
    do_cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3);

    // 256 consecutive writes to R1 from reset: counter wraps to zero.
    do_cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd1);
    last_wd = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      last_wd = 16'($urandom);
      do_cycle(1'b0, 1'b1, 3'd1, last_wd, 3'd1, 3'($urandom_range(0, 7)));
    end
    do_cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd1);
    chk("r1_last", QA, last_wd);
    chk("wcnt_wrap", {8'd0, WCNT}, 16'h0000);

    // Mixed random traffic, occasional reset.
    for (int i = 0; i < 60; i++) begin
      do_cycle(($urandom_range(0, 29) == 0), 1'($urandom), 3'($urandom), 16'($urandom),
               3'($urandom), 3'($urandom));
    end

    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_8x16.md
REGISTER_FILE_8X16 -- requirements
Module: register_file_8x16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of every register and data port.
REQ-002 The block SHALL have parameter BYPASS, default 1; 1 forwards same-cycle write data to the read ports, 0 disables forwarding.
REQ-003 The block SHALL have parameter ZERO_R0, default 1; 1 makes register 0 read as constant zero and ignore writes.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 WE  input  1  write enable for the write port.
REQ-007 WA  input  3  write register address.
REQ-008 WD  input  WIDTH  write data.
REQ-009 RA  input  3  read address, port A (same encoding as the downstream 3-bit select {S2,S1,S0}).
REQ-010 RB  input  3  read address, port B.
REQ-011 QA  output  WIDTH  read data, port A.
REQ-012 QB  output  WIDTH  read data, port B.
REQ-013 WCNT  output  8  count of committed writes since reset, for bench/debug.

Function
REQ-014 Storage SHALL be 8 registers R0..R7 of WIDTH bits each.
REQ-015 On a rising clk edge with rst=0 and WE=1, R[WA] SHALL load WD; with WE=0 no register SHALL change.
REQ-016 With ZERO_R0=1, a write to WA=0 SHALL be discarded and SHALL NOT increment WCNT.
REQ-017 Reads SHALL be combinational: QA = R[RA], QB = R[RB], zero cycles of latency.
REQ-018 With ZERO_R0=1, reading address 0 SHALL return all-zeros regardless of stored contents.
REQ-019 With BYPASS=1, WE=1 and WA==RA (WA nonzero when ZERO_R0=1), QA SHALL equal WD in the same cycle; QB likewise for RB.
REQ-020 With BYPASS=0, QA/QB SHALL show the pre-write value until the edge, and the new value from the cycle after.
REQ-021 Both read ports SHALL be independent; RA==RB SHALL give QA==QB.
REQ-022 WCNT SHALL increment by 1 on each committed write and SHALL wrap from 255 to 0.
REQ-023 Writing the value already held SHALL still count as a committed write.
REQ-024 Unknown or X-free operation: every output SHALL be driven for all 8 address values; no latch SHALL be inferred.

Reset
REQ-025 On a rising clk edge with rst=1, R0..R7 SHALL clear to 0 and WCNT SHALL clear to 0.
REQ-026 rst SHALL take priority over WE; a write in a reset cycle SHALL be dropped.
REQ-027 After reset, QA and QB SHALL read 0 for every address until the first committed write; with BYPASS=1 a write in the first post-reset cycle SHALL still be forwarded.
REQ-028 Reset asserted mid-sequence SHALL discard all prior contents; there SHALL be no asynchronous path from rst to outputs except through the registered state.

Verification
REQ-029 Reset 2 cycles, then RA=3, RB=7 -> QA=0x0000, QB=0x0000, WCNT=0.
REQ-030 Write WA=5, WD=0xBEEF, WE=1 one cycle, then RA=5 -> QA=0xBEEF, WCNT=1; RB=4 -> QB=0x0000.
REQ-031 ZERO_R0=1: write WA=0, WD=0x1234 -> RA=0 gives QA=0x0000, WCNT unchanged.
REQ-032 BYPASS=1: WE=1, WA=2, WD=0xA5A5, RA=2, RB=2 in the same cycle -> QA=QB=0xA5A5 before the edge; BYPASS=0 -> old value 0x0000 before edge, 0xA5A5 after.
REQ-033 WE=1 and rst=1 together with WA=6, WD=0xFFFF -> after edge R6=0x0000, WCNT=0.
REQ-034 256 consecutive writes to WA=1 -> WCNT wraps to 0; R1 holds the last WD written.
